// File: rtl/sum_deser_pkg.sv
// sum_deser_pkg: shared state encodings and default frame width for sum_deserializer.
// Contents: state_t (ST_IDLE / ST_SHIFT / ST_DONE), SUM_DESER_WIDTH default WIDTH.
package sum_deser_pkg;
    localparam int SUM_DESER_WIDTH = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sum_deserializer_bit_counter.sv
// bit_counter: counts bits captured in the current frame.
// Ports: clk, reset (sync, active-high), clear_load (load 1: bit 0 taken this edge),
//        inc (advance one bit), count (bits captured so far), last (count == WIDTH-1).
module bit_counter
    import sum_deser_pkg::*;
#(
    parameter int WIDTH = SUM_DESER_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_load,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    logic [CNT_W-1:0] count_q, count_d;
    assign last  = count_q == CNT_W'(WIDTH - 1);
    assign count = count_q;
    // Saturates at WIDTH-1 so the count never wraps inside a frame.
    always_comb count_d = clear_load ? CNT_W'(1) : (inc && !last) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/sum_deserializer.sv
// sum_deserializer: captures an LSB-first serial sum into a parallel word with a one-cycle valid pulse.
// Ports: clk, reset (sync, active-high), start (bit 0 present on sin this cycle), sin (serial in),
//        result (last completed word), valid (result just updated), busy (frame in progress),
//        parity (XOR of the completed frame; only with SUM_DESER_PARITY_EN defined).
// Config: `define SUM_DESER_PARITY_EN adds the parity output.
module sum_deserializer
    import sum_deser_pkg::*;
#(
    parameter  int WIDTH = SUM_DESER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
`ifdef SUM_DESER_PARITY_EN
    ,
    output logic             parity
`endif
);
    state_t           state_q, state_d;
    // Only the upper WIDTH-1 bits are stored: the final bit goes straight into result.
    logic [WIDTH-1:1] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d, shifted;
    logic [CNT_W-1:0] count;
    logic             last, in_shift, frame_done, unused_count;
    bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_load(start),
        .inc       (in_shift && !start),
        .count     (count),
        .last      (last)
    );
    assign unused_count = ^count;
    assign in_shift     = state_q == ST_SHIFT;
    // start always wins: it aborts a frame in progress and takes sin as the new bit 0.
    assign frame_done   = in_shift && !start && last;
    assign shifted      = {sin, sr_q};
    assign busy         = in_shift;
    assign valid        = state_q == ST_DONE;
    assign result       = result_q;
    always_comb begin
        sr_d     = (start || in_shift) ? shifted[WIDTH-1:1] : sr_q;
        result_d = frame_done ? shifted : result_q;
        state_d  = start ? ST_SHIFT : frame_done ? ST_DONE : in_shift ? ST_SHIFT : ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            result_q <= result_d;
        end
    end
`ifdef SUM_DESER_PARITY_EN
    logic acc_q, acc_d, parity_q, parity_d;
    assign parity = parity_q;
    always_comb begin
        acc_d    = start ? sin : in_shift ? acc_q ^ sin : acc_q;
        parity_d = frame_done ? acc_q ^ sin : parity_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            parity_q <= parity_d;
        end
    end
`endif
endmodule

// File: tb/tb_sum_deserializer.sv
// tb_sum_deserializer: directed + random self-checking bench for sum_deserializer against a frame-level model.
module tb_sum_deserializer;
    localparam int W = 4;
    logic         clk = 1'b0, reset = 1'b1, start = 1'b0, sin = 1'b0;
    logic [W-1:0] result;
    logic         valid, busy;
`ifdef SUM_DESER_PARITY_EN
    logic         parity;
`endif
    sum_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sin   (sin),
        .result(result),
        .valid (valid),
        .busy  (busy)
`ifdef SUM_DESER_PARITY_EN
        ,
        .parity(parity)
`endif
    );
    always #5 clk = ~clk;
    int           total = 0, bad = 0;
    // Model: bits of the frame in progress collected by index; pos = bits captured (0 = no frame).
    logic [W-1:0] frame = '0, exp_result = '0;
    int           pos = 0;
    logic         exp_valid = 1'b0, exp_busy = 1'b0, exp_parity = 1'b0;
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic s, input logic b);
        reset = r;
        start = s;
        sin   = b;
        @(posedge clk);
        exp_valid = 1'b0;
        if (r) begin
            pos        = 0;
            frame      = '0;
            exp_result = '0;
            exp_parity = 1'b0;
        end else if (s) begin
            frame    = '0;
            frame[0] = b;
            pos      = 1;
        end else if (pos > 0) begin
            frame[pos] = b;
            pos++;
            if (pos == W) begin
                exp_result = frame;
                exp_parity = ^frame;
                exp_valid  = 1'b1;
                pos        = 0;
            end
        end
        exp_busy = pos > 0;
        #1;
        check("valid", W'(valid), W'(exp_valid));
        check("busy", W'(busy), W'(exp_busy));
        check("result", result, exp_result);
`ifdef SUM_DESER_PARITY_EN
        check("parity", W'(parity), W'(exp_parity));
`endif
    endtask
    task automatic frame_in(input logic [W-1:0] bits);
        for (int i = 0; i < W; i++) step(1'b0, i == 0, bits[i]);
    endtask
    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("reset_result", result, '0);
        // Basic frame 1,1,0,1 LSB first.
        frame_in(4'b1011);
        check("basic_result", result, 4'b1011);
        check("basic_valid", W'(valid), W'(1'b1));
        step(1'b0, 1'b0, 1'b1);
        // Max sum, then back-to-back frame started in the DONE cycle.
        frame_in(4'b1110);
        check("max_result", result, 4'b1110);
        frame_in(4'b0001);
        check("b2b_result", result, 4'b0001);
        step(1'b0, 1'b0, 1'b0);
        // Restart mid-frame.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        frame_in(4'b0100);
        check("restart_result", result, 4'b0100);
        step(1'b0, 1'b0, 1'b0);
        // Reset mid-frame.
        frame_in(4'b1011);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("rst_mid_result", result, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        // Idle noise after a completed frame.
        frame_in(4'b0011);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i[0]);
        check("idle_result", result, 4'b0011);
        // Parity frames (checked per step when enabled).
        frame_in(4'b1011);
        frame_in(4'b0011);
        step(1'b0, 1'b0, 1'b0);
        // Random traffic with occasional resets and restarts.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0, 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
